// File: rtl/spsram_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port SRAM; read data returns to the issuer.
// Define SPSRAM_ARB_RDREG_EN to register the response, which raises the read latency from 2 to 3 cycles.
module spsram_arbiter #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_m0_valid,
    output logic              o_m0_ready,
    input  logic              i_m0_wr,
    input  logic [AWIDTH-1:0] i_m0_addr,
    input  logic [DWIDTH-1:0] i_m0_wdata,
    output logic              o_m0_rvalid,
    input  logic              i_m1_valid,
    output logic              o_m1_ready,
    input  logic              i_m1_wr,
    input  logic [AWIDTH-1:0] i_m1_addr,
    input  logic [DWIDTH-1:0] i_m1_wdata,
    output logic              o_m1_rvalid,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_sram_cen,
    output logic              o_sram_wen,
    output logic              o_sram_oen,
    output logic [AWIDTH-1:0] o_sram_addr,
    output logic [DWIDTH-1:0] o_sram_data,
    input  logic [DWIDTH-1:0] i_sram_data,
    output logic              o_busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              cen_q, cen_d, wen_q, wen_d, oen_q, oen_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              s1_valid_q, s1_valid_d, s1_id_q, s1_id_d, s1_rd_q, s1_rd_d;
    logic              s2_valid_q, s2_valid_d, s2_rv0_q, s2_rv0_d, s2_rv1_q, s2_rv1_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              grant0_s, grant1_s, hs_s, sel_wr_s, resp_s, inflight_s;
`ifdef SPSRAM_ARB_RDREG_EN
    logic              s3_valid_q, s3_valid_d, s3_rv0_q, s3_rv0_d, s3_rv1_q, s3_rv1_d;
`endif

    // Round-robin grant: last_grant_q=1 means m1 won last, so m0 wins the next tie.
    always_comb begin
        grant0_s = i_m0_valid & (~i_m1_valid | last_grant_q) & ~i_rst;
        grant1_s = i_m1_valid & (~i_m0_valid | ~last_grant_q) & ~i_rst;
        hs_s     = grant0_s | grant1_s;
        sel_wr_s = grant1_s ? i_m1_wr : i_m0_wr;
        resp_s   = s2_rv0_q | s2_rv1_q;
    end

    // Next state of the issue registers, tag pipeline and control FSM.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant1_s) begin
            last_grant_d = 1'b1;
        end else if (grant0_s) begin
            last_grant_d = 1'b0;
        end else begin
            last_grant_d = last_grant_q;
        end
        cen_d      = hs_s;
        wen_d      = hs_s & sel_wr_s;
        oen_d      = hs_s & ~sel_wr_s;
        addr_d     = hs_s ? (grant1_s ? i_m1_addr : i_m0_addr) : addr_q;
        data_d     = hs_s ? (grant1_s ? i_m1_wdata : i_m0_wdata) : data_q;
        s1_valid_d = hs_s;
        s1_id_d    = grant1_s;
        s1_rd_d    = hs_s & ~sel_wr_s;
        s2_valid_d = s1_valid_q;
        s2_rv0_d   = s1_valid_q & s1_rd_q & ~s1_id_q;
        s2_rv1_d   = s1_valid_q & s1_rd_q & s1_id_q;
        // SRAM output is only valid in the response cycle, so capture it there to hold it afterwards.
        rdata_d    = resp_s ? i_sram_data : rdata_q;
`ifdef SPSRAM_ARB_RDREG_EN
        s3_valid_d = s2_valid_q;
        s3_rv0_d   = s2_rv0_q;
        s3_rv1_d   = s2_rv1_q;
        inflight_s = s1_valid_d | s2_valid_d | s3_valid_d;
`else
        inflight_s = s1_valid_d | s2_valid_d;
`endif
        state_d = inflight_s ? ST_ACTIVE : ST_IDLE;
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cen_q        <= 1'b0;
            wen_q        <= 1'b0;
            oen_q        <= 1'b0;
            addr_q       <= {AWIDTH{1'b0}};
            data_q       <= {DWIDTH{1'b0}};
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_rd_q      <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_rv0_q     <= 1'b0;
            s2_rv1_q     <= 1'b0;
            rdata_q      <= {DWIDTH{1'b0}};
`ifdef SPSRAM_ARB_RDREG_EN
            s3_valid_q   <= 1'b0;
            s3_rv0_q     <= 1'b0;
            s3_rv1_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cen_q        <= cen_d;
            wen_q        <= wen_d;
            oen_q        <= oen_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_rd_q      <= s1_rd_d;
            s2_valid_q   <= s2_valid_d;
            s2_rv0_q     <= s2_rv0_d;
            s2_rv1_q     <= s2_rv1_d;
            rdata_q      <= rdata_d;
`ifdef SPSRAM_ARB_RDREG_EN
            s3_valid_q   <= s3_valid_d;
            s3_rv0_q     <= s3_rv0_d;
            s3_rv1_q     <= s3_rv1_d;
`endif
        end
    end

    assign o_m0_ready  = grant0_s;
    assign o_m1_ready  = grant1_s;
    assign o_sram_cen  = cen_q;
    assign o_sram_wen  = wen_q;
    assign o_sram_oen  = oen_q;
    assign o_sram_addr = addr_q;
    assign o_sram_data = data_q;
    assign o_busy      = (state_q == ST_ACTIVE);
`ifdef SPSRAM_ARB_RDREG_EN
    assign o_m0_rvalid = s3_rv0_q;
    assign o_m1_rvalid = s3_rv1_q;
    assign o_rdata     = rdata_q;
`else
    assign o_m0_rvalid = s2_rv0_q;
    assign o_m1_rvalid = s2_rv1_q;
    // Same-cycle bypass keeps the read latency at two cycles; rdata_q holds the value afterwards.
    assign o_rdata     = resp_s ? i_sram_data : rdata_q;
`endif

endmodule

// File: tb/tb_spsram_arbiter.sv
// Directed bench for spsram_arbiter with a behavioural synchronous SRAM attached to its SRAM port.
module tb_spsram_arbiter;

`ifdef SPSRAM_ARB_RDREG_EN
    localparam int RL = 3;
`else
    localparam int RL = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_ready, m0_wr, m0_rvalid;
    logic        m1_valid, m1_ready, m1_wr, m1_rvalid;
    logic [5:0]  m0_addr, m1_addr, sram_addr;
    logic [63:0] m0_wdata, m1_wdata, rdata, sram_wdata, sram_q;
    logic        sram_cen, sram_wen, sram_oen, busy;
    logic [63:0] mem [0:63];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        exp_rv0  [0:1023];
    logic        exp_rv1  [0:1023];
    logic        exp_cen  [0:1023];
    logic        exp_wen  [0:1023];
    logic        exp_oen  [0:1023];
    logic [5:0]  exp_addr [0:1023];
    logic [63:0] exp_wdat [0:1023];
    logic [63:0] exp_rd   [0:1023];

    spsram_arbiter #(.DWIDTH(64), .AWIDTH(6)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_valid(m0_valid), .o_m0_ready(m0_ready), .i_m0_wr(m0_wr),
        .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .o_m0_rvalid(m0_rvalid),
        .i_m1_valid(m1_valid), .o_m1_ready(m1_ready), .i_m1_wr(m1_wr),
        .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .o_m1_rvalid(m1_rvalid),
        .o_rdata(rdata), .o_sram_cen(sram_cen), .o_sram_wen(sram_wen), .o_sram_oen(sram_oen),
        .o_sram_addr(sram_addr), .o_sram_data(sram_wdata), .i_sram_data(sram_q), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM: write or read on a cycle with cen set, read data one cycle later.
    always @(posedge clk) begin
        if (sram_cen && sram_wen) mem[sram_addr] <= sram_wdata;
        if (sram_cen && sram_oen) sram_q <= mem[sram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // Per-cycle comparison of responses and SRAM controls against the expectation tables.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("m0_rvalid", m0_rvalid, exp_rv0[cyc]);
            chk("m1_rvalid", m1_rvalid, exp_rv1[cyc]);
            if (exp_rv0[cyc] || exp_rv1[cyc]) chk("rdata", rdata, exp_rd[cyc]);
            chk("sram_cen", sram_cen, exp_cen[cyc]);
            chk("sram_wen", sram_wen, exp_wen[cyc]);
            chk("sram_oen", sram_oen, exp_oen[cyc]);
            if (exp_cen[cyc]) chk("sram_addr", sram_addr, exp_addr[cyc]);
            if (exp_wen[cyc]) chk("sram_data", sram_wdata, exp_wdat[cyc]);
        end
    end

    task automatic record(input int c, input logic id, input logic wr, input logic [5:0] a,
                          input logic [63:0] d, input logic [63:0] erd);
        exp_cen[c+1]  = 1'b1;
        exp_wen[c+1]  = wr;
        exp_oen[c+1]  = ~wr;
        exp_addr[c+1] = a;
        exp_wdat[c+1] = d;
        if (!wr) begin
            if (id) exp_rv1[c+RL] = 1'b1;
            else    exp_rv0[c+RL] = 1'b1;
            exp_rd[c+RL] = erd;
        end
    endtask

    task automatic cyc_op(input string tag,
                          input logic v0, input logic w0, input logic [5:0] a0, input logic [63:0] d0,
                          input logic v1, input logic w1, input logic [5:0] a1, input logic [63:0] d1,
                          input logic g0, input logic g1, input logic [63:0] erd);
        int c;
        @(posedge clk); #1;
        m0_valid = v0; m0_wr = w0; m0_addr = a0; m0_wdata = d0;
        m1_valid = v1; m1_wr = w1; m1_addr = a1; m1_wdata = d1;
        c = cyc;
        @(negedge clk);
        chk({tag, "_rdy0"}, m0_ready, g0);
        chk({tag, "_rdy1"}, m1_ready, g1);
        if (g0) record(c, 1'b0, w0, a0, d0, erd);
        if (g1) record(c, 1'b1, w1, a1, d1, erd);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            m0_valid = 1'b0;
            m1_valid = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin
            exp_rv0[k] = 1'b0; exp_rv1[k] = 1'b0; exp_cen[k] = 1'b0; exp_wen[k] = 1'b0;
            exp_oen[k] = 1'b0; exp_addr[k] = 6'd0; exp_wdat[k] = 64'd0; exp_rd[k] = 64'd0;
        end
        rst = 1'b1;
        m0_valid = 1'b1; m0_wr = 1'b0; m0_addr = 6'd1; m0_wdata = 64'd0;
        m1_valid = 1'b1; m1_wr = 1'b1; m1_addr = 6'd2; m1_wdata = 64'd0;

        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_rdy0", m0_ready, 1'b0);
            chk("rst_rdy1", m1_ready, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rdata", rdata, 64'd0);
            chk("rst_addr", sram_addr, 6'd0);
            chk("rst_data", sram_wdata, 64'd0);
        end
        rst = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;

        for (int i = 0; i < 64; i++) begin
            cyc_op("wr", 1'b1, 1'b1, 6'(i), 64'd1 << i, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 64'd0);
            if (i == 10) chk("busy_stream", busy, 1'b1);
        end
        for (int i = 0; i < 64; i++) begin
            cyc_op("rd", 1'b1, 1'b0, 6'(i), 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 64'd1 << i);
        end
        idle(5);
        @(negedge clk);
        chk("busy_drained", busy, 1'b0);
        chk("rdata_hold", rdata, 64'd1 << 63);

        // Reset restores m0 as the winner of the first tie.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1; rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            cyc_op("alt", 1'b1, 1'b0, 6'd5, 64'd0, 1'b1, 1'b0, 6'd9, 64'd0,
                   (k % 2) == 0, (k % 2) == 1, ((k % 2) == 0) ? (64'd1 << 5) : (64'd1 << 9));
        end
        idle(5);
        @(negedge clk);
        chk("rdata_hold_alt", rdata, 64'd1 << 9);

        cyc_op("wr3", 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 6'd3, 64'hDEAD_BEEF, 1'b0, 1'b1, 64'd0);
        cyc_op("rd3", 1'b1, 1'b0, 6'd3, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 64'hDEAD_BEEF);
        idle(5);

        // Read accepted, then reset in the following cycle: its response must never appear.
        cyc_op("rst_rd", 1'b1, 1'b0, 6'd5, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        exp_rv0[cyc+RL] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", busy, 1'b0);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
